// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the ID stage and the hazard sequencer.
// The master side drives ID/EX status; the slave side (hazard_ctrl) returns stall controls.
`timescale 1ns/1ps
interface hazard_ctrl_if;
  logic       id_valid;
  logic       id_rs_read;
  logic       id_rt_read;
  logic [4:0] id_rs_addr;
  logic [4:0] id_rt_addr;
  logic       id_md_op;
  logic       ex_load;
  logic [4:0] ex_write_addr;
  logic       id_branch_taken;
  logic       stall_pc;
  logic       stall_if;
  logic       stall_id;
  logic       bubble_ex;
  logic       md_go;
  logic       md_busy;
  logic       md_done;
  logic       flush_if;

  modport master (
    output id_valid, id_rs_read, id_rt_read, id_rs_addr, id_rt_addr, id_md_op,
    output ex_load, ex_write_addr, id_branch_taken,
    input  stall_pc, stall_if, stall_id, bubble_ex, md_go, md_busy, md_done, flush_if
  );

  modport slave (
    input  id_valid, id_rs_read, id_rt_read, id_rs_addr, id_rt_addr, id_md_op,
    input  ex_load, ex_write_addr, id_branch_taken,
    output stall_pc, stall_if, stall_id, bubble_ex, md_go, md_busy, md_done, flush_if
  );
endinterface

// File: rtl/hazard_ctrl.sv
// ID-stage sequencer: load-use hazard stalls and multi-cycle mult/div sequencing.
// Optional branch flush of IF/ID is enabled by defining HAZARD_BRANCH_FLUSH_EN.
`timescale 1ns/1ps
module hazard_ctrl #(
  parameter int unsigned LOAD_BUBBLES = 1,
  parameter int unsigned MD_CYCLES    = 32
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);

  // Counter must hold both MD_CYCLES-2 and LOAD_BUBBLES-2.
  localparam int unsigned CntMax = (MD_CYCLES > LOAD_BUBBLES) ? MD_CYCLES : LOAD_BUBBLES;
  localparam int unsigned CntW   = $clog2(CntMax);

  typedef enum logic [1:0] {StIdle, StLoadWait, StMdBusy} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            load_use;
  logic            stall, bubble, md_go, md_busy, md_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    load_use = hz.id_valid && hz.ex_load && (hz.ex_write_addr != 5'd0) &&
               ((hz.id_rs_read && (hz.id_rs_addr == hz.ex_write_addr)) ||
                (hz.id_rt_read && (hz.id_rt_addr == hz.ex_write_addr)));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    bubble  = 1'b0;
    md_go   = 1'b0;
    md_busy = 1'b0;
    md_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load_use) begin
          stall  = 1'b1;
          bubble = 1'b1;
          if (LOAD_BUBBLES > 1) begin
            state_d = StLoadWait;
            cnt_d   = CntW'(LOAD_BUBBLES - 2);
          end
        end else if (hz.id_valid && hz.id_md_op) begin
          md_go   = 1'b1;
          stall   = 1'b1;
          bubble  = 1'b1;
          state_d = StMdBusy;
          cnt_d   = CntW'(MD_CYCLES - 2);
        end
      end
      StLoadWait: begin
        stall  = 1'b1;
        bubble = 1'b1;
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StMdBusy: begin
        md_busy = 1'b1;
        if (cnt_q != '0) begin
          stall  = 1'b1;
          bubble = 1'b1;
          cnt_d  = cnt_q - CntW'(1);
        end else begin
          // Result ready: release ID so the mult/div instruction advances.
          md_done = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are forced low while reset is held, even if ID still presents work.
  always_comb begin
    hz.stall_pc  = stall & ~rst;
    hz.stall_if  = stall & ~rst;
    hz.stall_id  = stall & ~rst;
    hz.bubble_ex = bubble & ~rst;
    hz.md_go     = md_go & ~rst;
    hz.md_busy   = md_busy & ~rst;
    hz.md_done   = md_done & ~rst;
  end

`ifdef HAZARD_BRANCH_FLUSH_EN
  // A stalled branch re-resolves once operands are valid, so no flush yet.
  always_comb begin
    hz.flush_if = hz.id_branch_taken & ~(stall & ~rst) & ~rst;
  end
`else
  logic unused_branch_taken;
  always_comb begin
    unused_branch_taken = hz.id_branch_taken;
    hz.flush_if         = 1'b0;
  end
`endif

endmodule
